// File: rtl/pcm_rom_fetch.sv
// YM2610 sample-ROM fetch: synchronises the ADPCM-A/B address buses, assembles 24-bit byte
// addresses and shares one SDRAM read port between the two channels (round-robin).
module pcm_rom_fetch #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [23:0] B_OFFSET    = 24'h000000
) (
   input  logic        CLK_24M,
   input  logic        nRESET,
   input  logic        SDRMPX,
   input  logic        nSDROE,
   input  logic [7:0]  SDRAD_IN,
   input  logic [1:0]  SDRA_L,
   input  logic [3:0]  SDRA_U,
   input  logic        SDPMPX,
   input  logic        nSDPOE,
   input  logic [7:0]  SDPAD_IN,
   input  logic [3:0]  SDPA,
   output logic [7:0]  SDRAD_OUT,
   output logic        SDRAD_OE,
   output logic [7:0]  SDPAD_OUT,
   output logic        SDPAD_OE,
   output logic        ROM_REQ,
   output logic [23:0] ROM_ADDR,
   input  logic        ROM_ACK,
   input  logic [7:0]  ROM_DATA
);

   typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

   function automatic logic [23:0] wrap_add24(input logic [23:0] a, input logic [23:0] b);
      return a + b;
   endfunction

   // A bus packed as {MPX, U[3:0], L[1:0], AD[7:0]}; B bus as {MPX, PA[3:0], AD[7:0]}
   logic [14:0] a_sync  [SYNC_STAGES];
   logic [12:0] b_sync  [SYNC_STAGES];
   logic [1:0]  oe_sync [SYNC_STAGES];
   logic        a_mpx_d;
   logic        b_mpx_d;

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            a_sync[i]  <= '0;
            b_sync[i]  <= '0;
            oe_sync[i] <= '0;
         end
         a_mpx_d <= 1'b0;
         b_mpx_d <= 1'b0;
      end else begin
         a_sync[0]  <= {SDRMPX, SDRA_U, SDRA_L, SDRAD_IN};
         b_sync[0]  <= {SDPMPX, SDPA, SDPAD_IN};
         oe_sync[0] <= {~nSDROE, ~nSDPOE};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            a_sync[i]  <= a_sync[i-1];
            b_sync[i]  <= b_sync[i-1];
            oe_sync[i] <= oe_sync[i-1];
         end
         a_mpx_d <= a_sync[SYNC_STAGES-1][14];
         b_mpx_d <= b_sync[SYNC_STAGES-1][12];
      end
   end

   // ---- synchronised stage: strobe edges and bus bits come from the same flop ----
   logic [14:0] a_s;
   logic [12:0] b_s;
   logic        a_rise;
   logic        a_fall;
   logic        b_rise;
   logic        b_fall;

   assign a_s      = a_sync[SYNC_STAGES-1];
   assign b_s      = b_sync[SYNC_STAGES-1];
   assign a_rise   = a_s[14] & ~a_mpx_d;
   assign a_fall   = ~a_s[14] & a_mpx_d;
   assign b_rise   = b_s[12] & ~b_mpx_d;
   assign b_fall   = ~b_s[12] & b_mpx_d;
   assign SDRAD_OE = oe_sync[SYNC_STAGES-1][1];
   assign SDPAD_OE = oe_sync[SYNC_STAGES-1][0];

   // ---- address assembly and pending flags ----
   logic [23:0] addr_a;
   logic [23:0] addr_b;
   logic        pend_a;
   logic        pend_b;
   logic        pick_a;
   logic        pick_b;

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         addr_a <= '0;
         addr_b <= '0;
         pend_a <= 1'b0;
         pend_b <= 1'b0;
      end else begin
         if (a_fall) addr_a[9:0]   <= a_s[9:0];
         if (a_rise) addr_a[23:10] <= a_s[13:0];
         if (b_fall) addr_b[11:0]  <= b_s[11:0];
         if (b_rise) addr_b[23:12] <= b_s[11:0];
         // a fresh capture wins over the clear from being picked in the same cycle
         if (a_rise)      pend_a <= 1'b1;
         else if (pick_a) pend_a <= 1'b0;
         if (b_rise)      pend_b <= 1'b1;
         else if (pick_b) pend_b <= 1'b0;
      end
   end

   // ---- request FSM ----
   state_t      state_q;
   state_t      state_d;
   logic        served_a_q;
   logic        chan_b_q;
   logic [23:0] rom_addr_q;

   always_comb begin
      state_d = state_q;
      pick_a  = 1'b0;
      pick_b  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_a | pend_b) begin
               pick_b  = pend_b & (~pend_a | served_a_q);
               pick_a  = ~pick_b;
               state_d = REQ;
            end
         end
         REQ: begin
            if (ROM_ACK) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= IDLE;
         served_a_q <= 1'b0;
         chan_b_q   <= 1'b0;
         rom_addr_q <= '0;
         SDRAD_OUT  <= '0;
         SDPAD_OUT  <= '0;
      end else begin
         state_q <= state_d;
         if (pick_a | pick_b) begin
            rom_addr_q <= pick_b ? wrap_add24(addr_b, B_OFFSET) : addr_a;
            chan_b_q   <= pick_b;
            served_a_q <= pick_a;
         end
         if ((state_q == REQ) && ROM_ACK) begin
            if (chan_b_q) SDPAD_OUT <= ROM_DATA;
            else          SDRAD_OUT <= ROM_DATA;
         end
      end
   end

   assign ROM_REQ  = (state_q == REQ);
   assign ROM_ADDR = rom_addr_q;

endmodule

// File: tb/tb_pcm_rom_fetch.sv
// Directed bench for pcm_rom_fetch: address assembly, latency, round-robin, hold-until-ack, reset.
module tb_pcm_rom_fetch;

   localparam int          SYNC_STAGES = 2;
   localparam logic [23:0] B_OFFSET    = 24'h800000;

   logic        CLK_24M = 1'b0;
   logic        nRESET;
   logic        SDRMPX;
   logic        nSDROE;
   logic [7:0]  SDRAD_IN;
   logic [1:0]  SDRA_L;
   logic [3:0]  SDRA_U;
   logic        SDPMPX;
   logic        nSDPOE;
   logic [7:0]  SDPAD_IN;
   logic [3:0]  SDPA;
   logic [7:0]  SDRAD_OUT;
   logic        SDRAD_OE;
   logic [7:0]  SDPAD_OUT;
   logic        SDPAD_OE;
   logic        ROM_REQ;
   logic [23:0] ROM_ADDR;
   logic        ROM_ACK;
   logic [7:0]  ROM_DATA;

   int total = 0;
   int bad   = 0;

   pcm_rom_fetch #(.SYNC_STAGES(SYNC_STAGES), .B_OFFSET(B_OFFSET)) dut (
      .CLK_24M  (CLK_24M),
      .nRESET   (nRESET),
      .SDRMPX   (SDRMPX),
      .nSDROE   (nSDROE),
      .SDRAD_IN (SDRAD_IN),
      .SDRA_L   (SDRA_L),
      .SDRA_U   (SDRA_U),
      .SDPMPX   (SDPMPX),
      .nSDPOE   (nSDPOE),
      .SDPAD_IN (SDPAD_IN),
      .SDPA     (SDPA),
      .SDRAD_OUT(SDRAD_OUT),
      .SDRAD_OE (SDRAD_OE),
      .SDPAD_OUT(SDPAD_OUT),
      .SDPAD_OE (SDPAD_OE),
      .ROM_REQ  (ROM_REQ),
      .ROM_ADDR (ROM_ADDR),
      .ROM_ACK  (ROM_ACK),
      .ROM_DATA (ROM_DATA)
   );

   always #5 CLK_24M = ~CLK_24M;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK_24M);
      #1;
   endtask

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit do_a, input bit do_b,
                       input logic [7:0] a_lo_ad, input logic [1:0] a_lo_l,
                       input logic [7:0] a_hi_ad, input logic [1:0] a_hi_l, input logic [3:0] a_hi_u,
                       input logic [7:0] b_lo_ad, input logic [3:0] b_lo_pa,
                       input logic [7:0] b_hi_ad, input logic [3:0] b_hi_pa);
      if (do_a) begin SDRAD_IN = a_lo_ad; SDRA_L = a_lo_l; end
      if (do_b) begin SDPAD_IN = b_lo_ad; SDPA = b_lo_pa; end
      tick(1);
      if (do_a) SDRMPX = 1'b0;
      if (do_b) SDPMPX = 1'b0;
      tick(4);
      if (do_a) begin SDRAD_IN = a_hi_ad; SDRA_L = a_hi_l; SDRA_U = a_hi_u; end
      if (do_b) begin SDPAD_IN = b_hi_ad; SDPA = b_hi_pa; end
      tick(1);
      if (do_a) SDRMPX = 1'b1;
      if (do_b) SDPMPX = 1'b1;
   endtask

   task automatic wait_req(input string tag, output int n);
      n = 0;
      while (ROM_REQ !== 1'b1 && n < 60) begin
         tick(1);
         n++;
      end
      check(tag, {23'd0, ROM_REQ}, 24'd1);
   endtask

   task automatic ack(input logic [7:0] d);
      ROM_DATA = d;
      ROM_ACK  = 1'b1;
      tick(1);
      ROM_ACK  = 1'b0;
      ROM_DATA = 8'h00;
   endtask

   initial begin
      int  n;
      bit  stable;
      nRESET = 1'b0; SDRMPX = 1'b0; SDPMPX = 1'b0; nSDROE = 1'b1; nSDPOE = 1'b1;
      SDRAD_IN = '0; SDRA_L = '0; SDRA_U = '0; SDPAD_IN = '0; SDPA = '0;
      ROM_ACK = 1'b0; ROM_DATA = '0;

      // reset state, during and after reset
      tick(2);
      check("rst_req",  {23'd0, ROM_REQ}, 24'd0);
      check("rst_addr", ROM_ADDR, 24'd0);
      check("rst_outs", {6'd0, SDRAD_OE, SDPAD_OE, SDRAD_OUT, SDPAD_OUT}, 24'd0);
      nRESET = 1'b1;
      tick(3);
      check("idle_req", {23'd0, ROM_REQ}, 24'd0);

      // both channels pending together after reset: A first, then B
      SDRMPX = 1'b1; SDPMPX = 1'b1;
      wait_req("rr1_req_a", n);
      check("rr1_lat", n, SYNC_STAGES + 2);
      check("rr1_addr_a", ROM_ADDR, 24'h000000);
      ack(8'h11);
      check("rr1_dout_a", SDRAD_OUT, 8'h11);
      check("rr1_gap", {23'd0, ROM_REQ}, 24'd0);
      wait_req("rr1_req_b", n);
      check("rr1_addr_b", ROM_ADDR, 24'h800000);
      ack(8'h22);
      check("rr1_dout_b", SDPAD_OUT, 8'h22);

      // B fetch with offset wrap
      send(0, 1, 8'h00, 2'd0, 8'h00, 2'd0, 4'd0, 8'h78, 4'h3, 8'hFF, 4'hF);
      wait_req("b_req", n);
      check("b_lat", n, SYNC_STAGES + 2);
      check("b_addr", ROM_ADDR, 24'h7FF378);
      ack(8'h5C);
      check("b_dout", SDPAD_OUT, 8'h5C);
      check("b_hold_a", SDRAD_OUT, 8'h11);
      check("b_req_drop", {23'd0, ROM_REQ}, 24'd0);

      // A fetch, address built from the bit fields
      send(1, 0, 8'h34, 2'd1, 8'h12, 2'd2, 4'd5, 8'h00, 4'h0, 8'h00, 4'h0);
      wait_req("a_req", n);
      check("a_lat", n, SYNC_STAGES + 2);
      check("a_addr", ROM_ADDR, 24'h584934);
      ack(8'hA5);
      check("a_dout", SDRAD_OUT, 8'hA5);
      check("a_req_drop", {23'd0, ROM_REQ}, 24'd0);
      tick(1);
      check("a_stay_idle", {23'd0, ROM_REQ}, 24'd0);

      send(1, 0, 8'h34, 2'd1, 8'h92, 2'd2, 4'd5, 8'h00, 4'h0, 8'h00, 4'h0);
      wait_req("a2_req", n);
      check("a2_addr", ROM_ADDR, 24'h5A4934);
      ack(8'h3C);
      check("a2_dout", SDRAD_OUT, 8'h3C);

      // output enables follow the synchronised pins
      nSDROE = 1'b0;
      tick(1);
      check("oe_a_early", {23'd0, SDRAD_OE}, 24'd0);
      tick(1);
      check("oe_a", {23'd0, SDRAD_OE}, 24'd1);
      nSDROE = 1'b1; nSDPOE = 1'b0;
      tick(2);
      check("oe_ab", {22'd0, SDRAD_OE, SDPAD_OE}, 24'd1);
      nSDPOE = 1'b1;
      tick(2);

      // both pending with A served last: B first, then A
      send(1, 1, 8'h01, 2'd0, 8'h00, 2'd0, 4'd0, 8'h02, 4'h0, 8'h00, 4'h0);
      wait_req("rr2_req_b", n);
      check("rr2_addr_b", ROM_ADDR, 24'h800002);
      ack(8'h66);
      check("rr2_dout_b", SDPAD_OUT, 8'h66);
      check("rr2_gap", {23'd0, ROM_REQ}, 24'd0);
      wait_req("rr2_req_a", n);
      check("rr2_addr_a", ROM_ADDR, 24'h000001);
      ack(8'h77);
      check("rr2_dout_a", SDRAD_OUT, 8'h77);

      // second A address while first is in flight with a slow ack
      send(1, 0, 8'h10, 2'd0, 8'h20, 2'd1, 4'd3, 8'h00, 4'h0, 8'h00, 4'h0);
      wait_req("ovl_req1", n);
      check("ovl_addr1", ROM_ADDR, 24'h348010);
      stable = 1'b1;
      send(1, 0, 8'hAB, 2'd3, 8'hCD, 2'd2, 4'hE, 8'h00, 4'h0, 8'h00, 4'h0);
      for (int i = 0; i < 14; i++) begin
         if (ROM_REQ !== 1'b1 || ROM_ADDR !== 24'h348010) stable = 1'b0;
         tick(1);
      end
      check("ovl_hold1", {23'd0, stable}, 24'd1);
      ack(8'h99);
      check("ovl_dout1", SDRAD_OUT, 8'h99);
      check("ovl_gap", {23'd0, ROM_REQ}, 24'd0);
      wait_req("ovl_req2", n);
      check("ovl_addr2", ROM_ADDR, 24'hEB37AB);
      ack(8'h88);
      check("ovl_dout2", SDRAD_OUT, 8'h88);

      // reset while a request is outstanding
      nSDROE = 1'b0;
      send(1, 0, 8'h55, 2'd0, 8'h01, 2'd0, 4'd0, 8'h00, 4'h0, 8'h00, 4'h0);
      wait_req("rst_mid_req", n);
      check("rst_mid_oe_pre", {23'd0, SDRAD_OE}, 24'd1);
      nRESET = 1'b0;
      #1;
      check("rst_mid_req0", {23'd0, ROM_REQ}, 24'd0);
      check("rst_mid_addr", ROM_ADDR, 24'd0);
      check("rst_mid_outs", {6'd0, SDRAD_OE, SDPAD_OE, SDRAD_OUT, SDPAD_OUT}, 24'd0);
      SDRMPX = 1'b0; SDPMPX = 1'b0; nSDROE = 1'b1;
      tick(3);
      nRESET = 1'b1;
      tick(2);
      ack(8'hEE);
      check("late_ack_outs", {8'd0, SDRAD_OUT, SDPAD_OUT}, 24'd0);
      check("late_ack_req", {23'd0, ROM_REQ}, 24'd0);
      tick(3);
      check("late_ack_idle", {23'd0, ROM_REQ}, 24'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
